// File: rtl/ysyx22040413_exu_adder_arb_pkg.sv
// Shared constants and types for the EXU shared-adder arbiter.
package ysyx22040413_exu_adder_arb_pkg;

    localparam int unsigned RV64_DATA_WIDTH = 64;

    // Grant encodings, also used as the stored last_grant value.
    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_PC  = 1'b1;

    // Bit positions of each requester inside the elig/grant vectors.
    localparam int unsigned IDX_ALU = 0;
    localparam int unsigned IDX_PC  = 1;

    typedef enum logic {
        PortAlu = GNT_ALU,
        PortPc  = GNT_PC
    } port_e;

endpackage

// File: rtl/ysyx22040413_rr_arb2.sv
// Two-way combinational arbiter: round-robin or fixed ALU priority on conflict.
module ysyx22040413_rr_arb2
    import ysyx22040413_exu_adder_arb_pkg::*;
(
    input  logic [1:0] elig,
    input  logic       last_grant,
    input  logic       rr_en,
    output logic [1:0] grant,
    output logic       conflict
);

    // Pick a winner; on a tie favour the port that did not win last time.
    always_comb begin
        grant    = 2'b00;
        conflict = elig[IDX_ALU] & elig[IDX_PC];
        if (conflict) begin
            if (rr_en && (last_grant == GNT_ALU)) begin
                grant[IDX_PC] = 1'b1;
            end else begin
                grant[IDX_ALU] = 1'b1;
            end
        end else begin
            grant = elig;
        end
    end

endmodule

// File: rtl/ysyx22040413_exu_adder_arb.sv
// One shared adder serving the ALU and PC-target paths, with a registered
// result slot per requester and a saturating conflict counter.
module ysyx22040413_exu_adder_arb
    import ysyx22040413_exu_adder_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RV64_DATA_WIDTH,
    parameter bit          RR_EN      = 1'b1,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_req_valid,
    output logic                  alu_req_ready,
    input  logic [DATA_WIDTH-1:0] alu_op1,
    input  logic [DATA_WIDTH-1:0] alu_op2,
    output logic                  alu_resp_valid,
    input  logic                  alu_resp_ready,
    output logic [DATA_WIDTH-1:0] alu_res,
    input  logic                  pc_req_valid,
    output logic                  pc_req_ready,
    input  logic                  pc_jalr,
    input  logic [DATA_WIDTH-1:0] pc_op1,
    input  logic [DATA_WIDTH-1:0] pc_op2,
    output logic                  pc_resp_valid,
    input  logic                  pc_resp_ready,
    output logic [DATA_WIDTH-1:0] pc_res,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    logic                  alu_resp_valid_q;
    logic                  pc_resp_valid_q;
    logic [DATA_WIDTH-1:0] alu_res_q;
    logic [DATA_WIDTH-1:0] pc_res_q;
    logic [CNT_WIDTH-1:0]  conflict_cnt_q;
    port_e                 last_grant_q;

    logic [1:0]            elig;
    logic [1:0]            grant;
    logic                  conflict;
    logic [DATA_WIDTH-1:0] add_op1;
    logic [DATA_WIDTH-1:0] add_op2;
    logic [DATA_WIDTH-1:0] add_sum;

    // A port competes only if its result slot is empty or drains this cycle.
    assign elig[IDX_ALU] = alu_req_valid & (~alu_resp_valid_q | alu_resp_ready);
    assign elig[IDX_PC]  = pc_req_valid  & (~pc_resp_valid_q  | pc_resp_ready);

    ysyx22040413_rr_arb2 u_arb (
        .elig       (elig),
        .last_grant (last_grant_q),
        .rr_en      (RR_EN),
        .grant      (grant),
        .conflict   (conflict)
    );

    assign alu_req_ready = grant[IDX_ALU];
    assign pc_req_ready  = grant[IDX_PC];

    // Shared adder: operands follow the grant; JALR targets drop bit 0.
    always_comb begin
        add_op1 = alu_op1;
        add_op2 = alu_op2;
        if (grant[IDX_PC]) begin
            add_op1 = pc_op1;
            add_op2 = pc_op2;
        end
        add_sum = add_op1 + add_op2;
        if (grant[IDX_PC] && pc_jalr) begin
            add_sum[0] = 1'b0;
        end
    end

    // ALU result slot: load on grant, drop valid on drain, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_resp_valid_q <= 1'b0;
            alu_res_q        <= '0;
        end else if (grant[IDX_ALU]) begin
            alu_resp_valid_q <= 1'b1;
            alu_res_q        <= add_sum;
        end else if (alu_resp_ready) begin
            alu_resp_valid_q <= 1'b0;
        end
    end

    // PC result slot: same policy as the ALU slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_resp_valid_q <= 1'b0;
            pc_res_q        <= '0;
        end else if (grant[IDX_PC]) begin
            pc_resp_valid_q <= 1'b1;
            pc_res_q        <= add_sum;
        end else if (pc_resp_ready) begin
            pc_resp_valid_q <= 1'b0;
        end
    end

    // Arbitration history and saturating count of contested cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q   <= PortPc;
            conflict_cnt_q <= '0;
        end else begin
            if (grant[IDX_ALU]) begin
                last_grant_q <= PortAlu;
            end else if (grant[IDX_PC]) begin
                last_grant_q <= PortPc;
            end
            if (conflict && (conflict_cnt_q != '1)) begin
                conflict_cnt_q <= conflict_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign alu_resp_valid = alu_resp_valid_q;
    assign alu_res        = alu_res_q;
    assign pc_resp_valid  = pc_resp_valid_q;
    assign pc_res         = pc_res_q;
    assign conflict_cnt   = conflict_cnt_q;

endmodule
